// File: rtl/load_store_pkg.sv
// Encodings shared by the load unit and the store-merge logic: load kinds,
// load FSM states and the wait-counter width.
package load_store_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        LT_LW   = 2'b00,
        LT_LH   = 2'b01,
        LT_LB   = 2'b10,
        LT_RSVD = 2'b11
    } load_type_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } load_state_e;

    function automatic logic isReserved(input logic [1:0] kind);
        return kind == LT_RSVD;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Lane extraction and zero-extension of a memory word. Lanes are always the
// low ones, which is where the store-merge path places narrow data.
module load_extract
    import load_store_pkg::*;
(
    input  logic [31:0] word,
    input  load_type_e  load_type,
    output logic [31:0] data
);

    always_comb begin
        data = '0;
        case (load_type)
            LT_LW:   data = word;
            LT_LH:   data = {16'h0, word[15:0]};
            LT_LB:   data = {24'h0, word[7:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: drives the address for MEM_LATENCY cycles,
// captures the returned word and presents the extracted result with a done pulse.
module load_unit
    import load_store_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] data_out
);

    // ADDR covers the first latency cycle, so WAIT only spans the remaining ones
    localparam logic [COUNT_W-1:0] WAIT_LAST =
        (MEM_LATENCY > 1) ? COUNT_W'(MEM_LATENCY - 2) : '0;

    load_state_e          state_q;
    load_type_e           loadType_q;
    logic [COUNT_W-1:0]   count_q;
    logic [31:0]          memAddr_q;
    logic [31:0]          dataOut_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic [31:0]          dataOut_d;

    load_extract uExtract (
        .word      (mem_rdata),
        .load_type (loadType_q),
        .data      (dataOut_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            loadType_q <= LT_LW;
            count_q    <= '0;
            memAddr_q  <= '0;
            dataOut_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        // Reserved kinds finish immediately without touching memory
                        if (isReserved(load_type)) begin
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            memAddr_q  <= addr;
                            loadType_q <= load_type_e'(load_type);
                            state_q    <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    count_q <= '0;
                    if (MEM_LATENCY > 1) begin
                        state_q <= WAIT;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                WAIT: begin
                    if (count_q == WAIT_LAST) begin
                        state_q <= CAPTURE;
                    end else begin
                        count_q <= count_q + COUNT_W'(1);
                    end
                end
                CAPTURE: begin
                    dataOut_q <= dataOut_d;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    busy_q    <= 1'b0;
                    memAddr_q <= '0;
                    count_q   <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    memAddr_q <= '0;
                    count_q   <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr = memAddr_q;
    assign mem_wr   = 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign data_out = dataOut_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit at latencies 1, 2 and 15 driven by one shared stimulus:
// directed vector table, hand-written multi-cycle sequences and random traffic.
module tb_load_unit;

    localparam int NDUT = 3;
    localparam logic [1:0] KIND_LW   = 2'b00;
    localparam logic [1:0] KIND_LH   = 2'b01;
    localparam logic [1:0] KIND_LB   = 2'b10;
    localparam logic [1:0] KIND_RSVD = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  loadType = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] memRdata = 32'h0;

    logic [31:0] memAddrO [NDUT];
    logic        memWrO   [NDUT];
    logic        busyO    [NDUT];
    logic        doneO    [NDUT];
    logic        errorO   [NDUT];
    logic [31:0] dataOutO [NDUT];

    int lat [NDUT] = '{1, 2, 15};
    int vecCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        load_unit #(
            .MEM_LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 15))
        ) uDut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .load_type (loadType),
            .addr      (addr),
            .mem_rdata (memRdata),
            .mem_addr  (memAddrO[g]),
            .mem_wr    (memWrO[g]),
            .busy      (busyO[g]),
            .done      (doneO[g]),
            .error     (errorO[g]),
            .data_out  (dataOutO[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        vecCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] kind, input logic [31:0] a,
                                 input logic [31:0] word);
        start    = s;
        loadType = kind;
        addr     = a;
        memRdata = word;
    endtask

    function automatic logic [31:0] refExtract(input logic [1:0] kind, input logic [31:0] w);
        case (kind)
            KIND_LW: return w;
            KIND_LH: return w % 32'h0001_0000;
            KIND_LB: return w % 32'h0000_0100;
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: a request accepted in cycle N occupies cycles N+1..end,
    // where end is N+1 for a reserved kind and N+2+latency otherwise.
    bit          modelOn = 1'b0;
    int          modelCycle = 0;
    bit          refActive [NDUT];
    int          refStart  [NDUT];
    bit          refRsvd   [NDUT];
    logic [31:0] refAddr   [NDUT];
    logic [1:0]  refType   [NDUT];
    logic [31:0] refData   [NDUT];
    int          mEnd;
    bit          mDone;
    logic [31:0] mAddr;

    always @(negedge clk) begin
        if (modelOn) begin
            for (int d = 0; d < NDUT; d++) begin
                mEnd  = refRsvd[d] ? refStart[d] + 1 : refStart[d] + 2 + lat[d];
                mDone = refActive[d] && (modelCycle == mEnd);
                mAddr = (refActive[d] && !refRsvd[d]) ? refAddr[d] : 32'h0;
                checkOutput($sformatf("L%0d busy", lat[d]), 32'(busyO[d]), 32'(refActive[d]));
                checkOutput($sformatf("L%0d done", lat[d]), 32'(doneO[d]), 32'(mDone));
                checkOutput($sformatf("L%0d error", lat[d]), 32'(errorO[d]), 32'(mDone && refRsvd[d]));
                checkOutput($sformatf("L%0d mem_addr", lat[d]), memAddrO[d], mAddr);
                checkOutput($sformatf("L%0d mem_wr", lat[d]), 32'(memWrO[d]), 32'h0);
                checkOutput($sformatf("L%0d data_out", lat[d]), dataOutO[d], refData[d]);
                if (refActive[d] && !refRsvd[d] && modelCycle == refStart[d] + 1 + lat[d]) begin
                    refData[d] = refExtract(refType[d], memRdata);
                end
                if (reset) begin
                    refActive[d] = 1'b0;
                    refData[d]   = 32'h0;
                end else if (refActive[d]) begin
                    if (modelCycle == mEnd) refActive[d] = 1'b0;
                end else if (start) begin
                    refActive[d] = 1'b1;
                    refStart[d]  = modelCycle;
                    refRsvd[d]   = (loadType == KIND_RSVD);
                    refAddr[d]   = addr;
                    refType[d]   = loadType;
                end
            end
            modelCycle++;
        end
    end

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] word;
        logic [31:0] wantData;
        int          wantDone;
        logic        wantErr;
        logic [31:0] wantAddr;
    } vec_t;

    vec_t vecs [6];
    int   doneCount;
    int   doneAt;
    int   firstDone  [NDUT];
    int   secondDone [NDUT];

    initial begin
        vecs[0] = '{KIND_LW,   32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 1'b0, 32'h0000_0010};
        vecs[1] = '{KIND_LH,   32'h0000_0020, 32'h1234_ABCD, 32'h0000_ABCD, 4, 1'b0, 32'h0000_0020};
        vecs[2] = '{KIND_LB,   32'h0000_0024, 32'h1234_ABCD, 32'h0000_00CD, 4, 1'b0, 32'h0000_0024};
        vecs[3] = '{KIND_RSVD, 32'h0000_0030, 32'h1234_ABCD, 32'h0000_00CD, 1, 1'b1, 32'h0000_0000};
        vecs[4] = '{KIND_LH,   32'h0000_0002, 32'hFFFF_8001, 32'h0000_8001, 4, 1'b0, 32'h0000_0002};
        vecs[5] = '{KIND_LB,   32'h0000_0003, 32'hABCD_EF9A, 32'h0000_009A, 4, 1'b0, 32'h0000_0003};
        for (int d = 0; d < NDUT; d++) begin
            refActive[d] = 1'b0;
            refStart[d]  = 0;
            refRsvd[d]   = 1'b0;
            refAddr[d]   = 32'h0;
            refType[d]   = 2'b00;
            refData[d]   = 32'h0;
        end

        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        modelOn = 1'b1;
        @(negedge clk);
        checkOutput("reset busy", 32'(busyO[1]), 32'h0);
        checkOutput("reset done", 32'(doneO[1]), 32'h0);
        checkOutput("reset error", 32'(errorO[1]), 32'h0);
        checkOutput("reset mem_addr", memAddrO[1], 32'h0);
        checkOutput("reset data_out", dataOutO[1], 32'h0);

        // Directed vectors against the latency-2 instance
        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            #1;
            applyStimulus(1'b1, vecs[v].kind, vecs[v].a, vecs[v].word);
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                @(negedge clk);
                checkOutput($sformatf("vec%0d busy c%0d", v, c), 32'(busyO[1]), 32'(c <= vecs[v].wantDone));
                checkOutput($sformatf("vec%0d done c%0d", v, c), 32'(doneO[1]), 32'(c == vecs[v].wantDone));
                checkOutput($sformatf("vec%0d error c%0d", v, c), 32'(errorO[1]),
                            32'(c == vecs[v].wantDone && vecs[v].wantErr));
                checkOutput($sformatf("vec%0d mem_addr c%0d", v, c), memAddrO[1],
                            (c <= vecs[v].wantDone) ? vecs[v].wantAddr : 32'h0);
                if (c >= vecs[v].wantDone)
                    checkOutput($sformatf("vec%0d data_out c%0d", v, c), dataOutO[1], vecs[v].wantData);
            end
            repeat (14) @(posedge clk);
        end

        // A start while busy must be dropped
        @(posedge clk);
        #1;
        applyStimulus(1'b1, KIND_LW, 32'h0000_0100, 32'h0BAD_F00D);
        doneCount = 0;
        doneAt = -1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(c == 2, KIND_LW, 32'h0000_0200, 32'h0BAD_F00D);
            @(negedge clk);
            if (c <= 4) checkOutput($sformatf("ignore mem_addr c%0d", c), memAddrO[1], 32'h0000_0100);
            if (doneO[1] === 1'b1) begin
                doneCount++;
                doneAt = c;
            end
        end
        checkOutput("ignore done count", doneCount, 1);
        checkOutput("ignore done cycle", doneAt, 4);
        checkOutput("ignore data_out", dataOutO[1], 32'h0BAD_F00D);
        repeat (20) @(posedge clk);

        // Reset in the middle of a request, then a fresh request
        @(posedge clk);
        #1;
        applyStimulus(1'b1, KIND_LW, 32'h0000_0040, 32'h1357_9BDF);
        doneCount = 0;
        doneAt = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            reset = (c == 3);
            applyStimulus(c == 5, KIND_LW, 32'h0000_0044, 32'h1357_9BDF);
            @(negedge clk);
            if (c == 4) begin
                checkOutput("abort busy", 32'(busyO[1]), 32'h0);
                checkOutput("abort done", 32'(doneO[1]), 32'h0);
                checkOutput("abort data_out", dataOutO[1], 32'h0);
            end
            if (doneO[1] === 1'b1) begin
                doneCount++;
                doneAt = c;
            end
        end
        checkOutput("restart done count", doneCount, 1);
        checkOutput("restart done cycle", doneAt, 9);
        checkOutput("restart data_out", dataOutO[1], 32'h1357_9BDF);
        repeat (20) @(posedge clk);

        // Back-to-back throughput sweep with start held high
        for (int d = 0; d < NDUT; d++) begin
            firstDone[d]  = -1;
            secondDone[d] = -1;
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b1, KIND_LW, 32'h0000_0080, 32'h2468_ACE0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = (c < 40);
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (doneO[d] === 1'b1) begin
                    if (firstDone[d] < 0) firstDone[d] = c;
                    else if (secondDone[d] < 0) secondDone[d] = c;
                end
            end
        end
        checkOutput("sweep L1 first done", firstDone[0], 3);
        checkOutput("sweep L1 second done", secondDone[0], 7);
        checkOutput("sweep L2 first done", firstDone[1], 4);
        checkOutput("sweep L2 second done", secondDone[1], 9);
        checkOutput("sweep L15 first done", firstDone[2], 17);
        checkOutput("sweep L15 second done", secondDone[2], 35);
        repeat (20) @(posedge clk);

        // Random traffic, judged by the reference model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, KIND_LW, 32'h0, 32'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
